// File: rtl/pmod_ad1_capture_ctrl_pkg.sv
// pmod_ad1_pkg: shared types and constants for the PMOD AD1 capture sequencer
package pmod_ad1_pkg;
  localparam int ADC_W = 12;
  localparam int BEAT_W = 16;
  localparam int CHAN_BIT = 12;
  localparam logic [1:0] TRIG_IMM = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, FLUSH, ABORTING} state_t;
  function automatic logic [BEAT_W-1:0] mk_beat(input logic ch, input logic [ADC_W-1:0] d);
    mk_beat = '0;
    mk_beat[ADC_W-1:0] = d;
    mk_beat[CHAN_BIT] = ch;
  endfunction
endpackage

// File: rtl/pmod_ad1_capture_ctrl_if.sv
// pmod_ad1_capture_ctrl_if: AXI4-Stream output channel of the capture sequencer
interface pmod_ad1_capture_ctrl_if;
  logic [pmod_ad1_pkg::BEAT_W-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  modport master(output tdata, output tvalid, output tlast, input tready);
  modport slave(input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/pmod_ad1_capture_ctrl_beat_buf.sv
// pmod_ad1_beat_buf: 2-entry ordered beat buffer whose head entry is the AXIS output register
module pmod_ad1_beat_buf
  import pmod_ad1_pkg::*;
(
  input logic CLK_i,
  input logic RST_i,
  input logic push,
  input logic two,
  input logic force_last,
  input logic [BEAT_W-1:0] d0,
  input logic [BEAT_W-1:0] d1,
  input logic l0,
  input logic l1,
  output logic empty,
  pmod_ad1_capture_ctrl_if.master axis
);
  logic [1:0] cnt;
  logic [BEAT_W-1:0] b0, b1;
  logic bl0, bl1;
  logic pop;
  assign pop = cnt != 2'd0 && axis.tready;
  assign empty = cnt == 2'd0 || (cnt == 2'd1 && pop);
  assign axis.tvalid = cnt != 2'd0;
  assign axis.tdata = b0;
  assign axis.tlast = cnt != 2'd0 && (bl0 || force_last);
  // load a whole sample when drained, truncate on abort, otherwise shift on handshake
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      cnt <= 2'd0;
      b0 <= '0;
      b1 <= '0;
      bl0 <= 1'b0;
      bl1 <= 1'b0;
    end else if (push) begin
      b0 <= d0;
      b1 <= d1;
      bl0 <= l0;
      bl1 <= l1;
      cnt <= two ? 2'd2 : 2'd1;
    end else if (force_last) begin
      bl0 <= 1'b1;
      cnt <= pop || cnt == 2'd0 ? 2'd0 : 2'd1;
    end else if (pop) begin
      b0 <= b1;
      bl0 <= bl1;
      cnt <= cnt - 2'd1;
    end
  end
endmodule

// File: rtl/pmod_ad1_capture_ctrl.sv
// pmod_ad1_capture_ctrl: schedules PMOD AD1 conversions, triggers, and frames results onto AXI4-Stream
module pmod_ad1_capture_ctrl
  import pmod_ad1_pkg::*;
#(
  parameter int MIN_PERIOD = 64,
  parameter int LEN_W = 16
) (
  input logic CLK_i,
  input logic RST_i,
  input logic CFG_START_i,
  input logic CFG_ABORT_i,
  input logic [15:0] CFG_PERIOD_i,
  input logic [LEN_W-1:0] CFG_LENGTH_i,
  input logic [1:0] CFG_TRIG_MODE_i,
  input logic [ADC_W-1:0] CFG_TRIG_LEVEL_i,
  input logic CFG_INTERLEAVE_i,
  output logic CONV_REQ_o,
  input logic CONV_BUSY_i,
  input logic [ADC_W-1:0] ADC_DATA0_i,
  input logic [ADC_W-1:0] ADC_DATA1_i,
  input logic ADC_VALID_i,
  pmod_ad1_capture_ctrl_if.master axis,
  output logic BUSY_o,
  output logic DONE_o,
  output logic OVERFLOW_o,
  output logic MISSED_o,
  output logic [LEN_W-1:0] SAMPLE_CNT_o
);
  state_t state, nxt;
  logic [15:0] per_q, tmr;
  logic [LEN_W-1:0] len_q, cnt_q, cnt_inc;
  logic [1:0] mode_q;
  logic [ADC_W-1:0] lvl_q, prev_q;
  logic il_q, primed_q, ovf_q, missed_q, done_q;
  logic run, pop, start_ok, fire, commit, drop, last_c, trunc, done_d, buf_empty;
  logic [BEAT_W-1:0] beat0, beat1;
  assign run = state == ARM || state == CAPTURE;
  assign pop = axis.tvalid && axis.tready;
  assign cnt_inc = cnt_q + 1'b1;
  assign last_c = cnt_inc == len_q;
  assign start_ok = CFG_START_i && !CFG_ABORT_i && CFG_LENGTH_i != '0;
  assign fire = mode_q == TRIG_RISE ? primed_q && prev_q < lvl_q && ADC_DATA0_i >= lvl_q :
                mode_q == TRIG_FALL ? primed_q && prev_q > lvl_q && ADC_DATA0_i <= lvl_q : 1'b1;
  assign commit = ADC_VALID_i && !CFG_ABORT_i && (state == ARM ? fire : state == CAPTURE && buf_empty);
  assign drop = ADC_VALID_i && !CFG_ABORT_i && state == CAPTURE && !buf_empty;
  assign trunc = CFG_ABORT_i && (state == CAPTURE || state == FLUSH) && axis.tvalid;
  assign done_d = state == FLUSH && !CFG_ABORT_i && pop && axis.tlast;
  assign beat0 = mk_beat(1'b0, ADC_DATA0_i);
  assign beat1 = mk_beat(1'b1, ADC_DATA1_i);
  assign CONV_REQ_o = run && tmr == '0 && !CONV_BUSY_i;
  assign BUSY_o = state != IDLE;
  assign DONE_o = done_q;
  assign OVERFLOW_o = ovf_q;
  assign MISSED_o = missed_q;
  assign SAMPLE_CNT_o = cnt_q;
  pmod_ad1_beat_buf u_buf (
    .CLK_i(CLK_i),
    .RST_i(RST_i),
    .push(commit),
    .two(il_q),
    .force_last(trunc),
    .d0(beat0),
    .d1(beat1),
    .l0(last_c && !il_q),
    .l1(last_c),
    .empty(buf_empty),
    .axis(axis)
  );
  // next state: abort beats everything, a truncated beat must still drain before IDLE
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = start_ok ? ARM : IDLE;
      ARM: nxt = CFG_ABORT_i ? IDLE : commit ? (last_c ? FLUSH : CAPTURE) : ARM;
      CAPTURE: nxt = CFG_ABORT_i ? (trunc && !pop ? ABORTING : IDLE) : commit && last_c ? FLUSH : CAPTURE;
      FLUSH: nxt = CFG_ABORT_i ? (pop ? IDLE : ABORTING) : done_d ? IDLE : FLUSH;
      ABORTING: nxt = pop ? IDLE : ABORTING;
      default: nxt = IDLE;
    endcase
  end
  // state register, request timer, configuration latch and status flags
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      state <= IDLE;
      tmr <= '0;
      per_q <= '0;
      len_q <= '0;
      cnt_q <= '0;
      mode_q <= '0;
      lvl_q <= '0;
      prev_q <= '0;
      il_q <= 1'b0;
      primed_q <= 1'b0;
      ovf_q <= 1'b0;
      missed_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      done_q <= done_d;
      tmr <= run && tmr != per_q - 16'd1 ? tmr + 16'd1 : '0;
      if (state == IDLE && start_ok) begin
        per_q <= CFG_PERIOD_i < 16'(MIN_PERIOD) ? 16'(MIN_PERIOD) : CFG_PERIOD_i;
        len_q <= CFG_LENGTH_i;
        mode_q <= CFG_TRIG_MODE_i;
        lvl_q <= CFG_TRIG_LEVEL_i;
        il_q <= CFG_INTERLEAVE_i;
        cnt_q <= '0;
        ovf_q <= 1'b0;
        missed_q <= 1'b0;
        primed_q <= 1'b0;
      end else begin
        if (commit) cnt_q <= cnt_inc;
        if (drop) ovf_q <= 1'b1;
        if (run && tmr == '0 && CONV_BUSY_i) missed_q <= 1'b1;
        if (state == ARM && ADC_VALID_i) begin
          prev_q <= ADC_DATA0_i;
          primed_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/pmod_ad1_capture_ctrl.md
Name: pmod_ad1_capture_ctrl

Overview:
- Sequencer that schedules conversions on the dual-channel PMOD AD1 front end and turns the results into AXI4-Stream frames.
- Issues periodic conversion requests to the ADC serial interface, evaluates an optional level trigger on channel 0, counts frame samples and applies TLAST.
- Buffers results against stream backpressure and flags dropped samples.
- Sits between the AD7476 serial engine and the DMA stream; configuration comes from the register file.

Parameters:
- MIN_PERIOD, 64, lower clamp on conversion period in CLK_i cycles; must cover one full serial conversion.
- LEN_W, 16, width of frame length and sample counter.

Ports:
- CLK_i  in  1  single clock for the whole block.
- RST_i  in  1  synchronous, active-high reset.
- CFG_START_i  in  1  one-cycle pulse that arms a capture.
- CFG_ABORT_i  in  1  one-cycle pulse that terminates an active capture.
- CFG_PERIOD_i  in  16  clocks between conversion requests.
- CFG_LENGTH_i  in  LEN_W  samples per frame.
- CFG_TRIG_MODE_i  in  2  trigger mode: 0 immediate, 1 rising, 2 falling, 3 reserved (treated as 0).
- CFG_TRIG_LEVEL_i  in  12  trigger threshold on channel 0.
- CFG_INTERLEAVE_i  in  1  0: channel 0 only; 1: channel 0 then channel 1 beat per sample.
- CONV_REQ_o  out  1  one-cycle request to the ADC engine.
- CONV_BUSY_i  in  1  ADC engine is mid-conversion.
- ADC_DATA0_i  in  12  channel 0 result.
- ADC_DATA1_i  in  12  channel 1 result.
- ADC_VALID_i  in  1  one-cycle strobe qualifying both data inputs.
- AXIS_TDATA_o  out  16  stream data.
- AXIS_TVALID_o  out  1  stream valid.
- AXIS_TREADY_i  in  1  stream ready.
- AXIS_TLAST_o  out  1  last beat of frame.
- BUSY_o  out  1  high while not IDLE.
- DONE_o  out  1  one-cycle pulse when a frame completes.
- OVERFLOW_o  out  1  sticky: a sample was dropped.
- MISSED_o  out  1  sticky: a request slot was skipped because the ADC was busy.
- SAMPLE_CNT_o  out  LEN_W  samples committed in the current or last frame.

Behaviour:
- Reset: state IDLE; every output 0; buffer empty; period timer 0.
- Config latching:
  - CFG_START_i in IDLE with CFG_LENGTH_i != 0 latches all CFG_* inputs, clears OVERFLOW_o, MISSED_o and SAMPLE_CNT_o, then enters ARM.
  - START with LENGTH == 0, or while not IDLE, is ignored.
- Effective period is max(CFG_PERIOD_i, MIN_PERIOD).
- Period timer:
  - Runs in ARM and CAPTURE; reloads to 0 on entry to ARM.
  - At timer == 0 it pulses CONV_REQ_o if CONV_BUSY_i == 0; otherwise no request and MISSED_o is set.
  - Wraps at period-1.
- ARM:
  - Mode 0: the first ADC_VALID_i is committed as sample 1 and the state moves to CAPTURE in the same cycle.
  - Modes 1 and 2: each valid updates prev = ADC_DATA0_i. The first valid after arming only primes prev.
  - Rising fires when prev < level and cur >= level. Falling fires when prev > level and cur <= level.
  - The firing sample is committed as sample 1 and the state moves to CAPTURE.
- CAPTURE:
  - Each ADC_VALID_i is committed only if the 2-entry output buffer is empty. Otherwise the sample is dropped, OVERFLOW_o is set and the sample is not counted.
  - A commit increments SAMPLE_CNT_o.
  - When the commit makes SAMPLE_CNT_o equal to LENGTH, the state moves to FLUSH and requests stop.
- Beat format:
  - TDATA = {3'b000, chan, 12'data}.
  - chan = 0 for channel 0. With interleave, the channel 1 beat follows with chan = 1.
  - TLAST is set on the final beat of sample LENGTH: the channel 0 beat without interleave, the channel 1 beat with it.
- Latency and handshake:
  - A committed sample presents TVALID on the cycle after ADC_VALID_i.
  - TVALID, TDATA and TLAST are held stable until TREADY.
  - The interleaved second beat follows on the cycle after the first beat's handshake.
  - Throughput is 1 beat per cycle.
- FLUSH: when the TLAST beat handshakes, DONE_o pulses for one cycle and the state returns to IDLE. BUSY_o drops in that same cycle.
- Abort:
  - CFG_ABORT_i in ARM, or in CAPTURE with the buffer empty: IDLE next cycle, no DONE.
  - In CAPTURE or FLUSH with a beat presented: keep that beat, force TLAST = 1 on it, discard the second buffered entry, stop requests. Go IDLE after its handshake, no DONE.
  - Abort in IDLE is ignored.
  - Abort and START in the same cycle: abort wins.
- ADC_VALID_i and a TREADY handshake on the last buffered beat in the same cycle: the buffer counts as empty, so the sample commits with no overflow.
- RST_i mid-frame: immediate return to reset values; no TLAST is emitted.

Decomposition:
- Package pmod_ad1_pkg holds:
  - the state enum (IDLE, ARM, CAPTURE, FLUSH, ABORTING);
  - the trigger-mode constants;
  - the beat channel-id bit position;
  - the ADC result width (12).
- Sub-module pmod_ad1_beat_buf: 2-entry ordered beat buffer with AXIS output register and a force-last input.

Test Plan:
- Immediate, no interleave, PERIOD=100, LENGTH=4, TREADY=1, ADC data 0x111..0x444 -> 4 beats 0x0111..0x0444 with TLAST only on 0x0444; DONE_o one pulse; SAMPLE_CNT_o=4; CONV_REQ_o spacing 100 cycles.
- PERIOD=10 -> CONV_REQ_o spacing clamped to 64.
- Rising trigger, level 0x800, ch0 sequence 0x900, 0x700, 0x7FF, 0x800, 0x900 -> the first sample only primes prev (0x900 does not trigger); first beat is 0x0800; LENGTH=2 frame = 0x0800, 0x0900.
- Interleave, LENGTH=2, ch0/ch1 = 0x0AA/0x0BB and 0x0CC/0x0DD -> beats 0x00AA, 0x10BB, 0x00CC, 0x10DD with TLAST on 0x10DD.
- TREADY held 0 while 3 ADC_VALID_i arrive -> first sample retained; next two dropped; OVERFLOW_o=1; SAMPLE_CNT_o=1; TDATA stable throughout.
- Abort mid-frame with interleaved pair buffered and TREADY=0 -> channel 0 beat kept with TLAST=1; channel 1 discarded; no DONE_o; IDLE after handshake. CONV_BUSY_i high at a request slot -> no CONV_REQ_o, MISSED_o=1.
